// File: rtl/qrisc32_wbuf.sv
// rtl/qrisc32_wbuf.sv - posted write buffer between the qrisc32 data-write master and data memory
// In-order circular FIFO with head-of-queue drain, newest-match read snoop and a flush FSM.
module qrisc32_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_wr,
  input  logic [AW-1:0]            s_addr,
  input  logic [DW-1:0]            s_data,
  output logic                     s_wait_req,
  input  logic                     s_rd,
  input  logic [AW-1:0]            s_raddr,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data,
  output logic                     m_wr,
  output logic [AW-1:0]            m_addr,
  output logic [DW-1:0]            m_data,
  input  logic                     m_wait_req,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {EMPTY, ACTIVE, FLUSH} state_t;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  state_t           state, state_d;
  logic             push, pop;

  assign push  = s_wr && !s_wait_req;
  assign pop   = m_wr && !m_wait_req;
  assign count = count_q;

  // Payload storage needs no reset: nothing reads it unless its valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= s_addr;
      data_q[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      EMPTY:   if (flush) state_d = FLUSH;
               else if (push) state_d = ACTIVE;
      ACTIVE:  if (flush) state_d = FLUSH;
               else if (pop && !push && count_q == ONE) state_d = EMPTY;
      FLUSH:   if (count_q == '0) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    s_wait_req = (count_q == FULL) || (state == FLUSH);
    flush_done = (state == FLUSH) && (count_q == '0);
    m_wr       = (count_q != '0);
    m_addr     = m_wr ? addr_q[rd_ptr] : '0;
    m_data     = m_wr ? data_q[rd_ptr] : '0;
  end

  // Walk oldest to newest so the last match wins; the head being popped still counts.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + i[PW-1:0];
      if (s_rd && valid_q[idx] && addr_q[idx] == s_raddr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: doc/qrisc32_wbuf.md
# qrisc32_wbuf

Posted write buffer between the qrisc32 Avalon data-write master (avm_dataw_*) and the data memory write port. CPU stores complete in one cycle while the buffer has room; entries drain in order to memory, honouring the memory's wait request. A read-snoop port detects loads that hit a pending store and forwards the newest matching data, so the load path never reads stale memory.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- AW, 32, address width
- DW, 32, data width
---
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- s_wr  in  1  CPU write request
- s_addr  in  AW  CPU write address
- s_data  in  DW  CPU write data
- s_wait_req  out  1  stall to CPU; write not accepted while high
- s_rd  in  1  CPU read in progress (snoop qualifier)
- s_raddr  in  AW  CPU read address
- fwd_hit  out  1  read address matches a pending entry
- fwd_data  out  DW  data of newest matching pending entry
- m_wr  out  1  memory write strobe
- m_addr  out  AW  memory write address
- m_data  out  DW  memory write data
- m_wait_req  in  1  memory stall
- flush  in  1  drain request (level)
- flush_done  out  1  one-cycle pulse when flush completes
- count  out  $clog2(DEPTH)+1  valid entries

## Operation
- Circular FIFO: storage addr/data per entry, valid bits, wr_ptr, rd_ptr, count; pointers wrap modulo DEPTH.
- Push: s_wr && !s_wait_req at clock edge → entry written at wr_ptr, wr_ptr++, count++.
- Pop: m_wr && !m_wait_req at clock edge → rd_ptr++, count--, valid cleared.
- Simultaneous push and pop: both occur, count unchanged.
- m_wr = (count != 0); m_addr/m_data = head entry (registered storage, no combinational path from s_*). Head held stable while m_wait_req high.
- s_wait_req = (count == DEPTH) || state == FLUSH. Full is evaluated on current count; a same-cycle pop does not unblock a push.
- Snoop (combinational): fwd_hit = s_rd && any valid entry with addr == s_raddr (full AW compare). fwd_data = data of the matching entry closest to wr_ptr (newest); 0 when fwd_hit low. Entry being popped this cycle still counts as pending.
- FSM states: EMPTY (count==0), ACTIVE (count>0), FLUSH.
  - EMPTY→ACTIVE on push; ACTIVE→EMPTY when last entry pops with no push.
  - EMPTY or ACTIVE → FLUSH when flush high. In FLUSH no pushes; drain continues.
  - FLUSH→EMPTY when count reaches 0 (including flush asserted while already empty: one cycle in FLUSH); flush_done pulses in the cycle the FSM leaves FLUSH.
  - flush held high after done: re-enters FLUSH next cycle, pulses again.
- Writes to the same address are not merged; each drains separately, in order.

## Timing
- Reset: all valid bits 0, pointers 0, count 0, state EMPTY; m_wr 0, m_addr 0, m_data 0, s_wait_req 0, fwd_hit 0, fwd_data 0, flush_done 0. Reset mid-drain discards pending entries; m_wr drops asynchronously.
- Write latency: push at edge N → m_wr high after edge N (first visible cycle N+1) when buffer was empty.
- Throughput: one push and one pop per cycle sustained with m_wait_req low.
- fwd_hit/fwd_data valid same cycle as s_raddr; entry pushed at edge N visible to snoop from edge N.
- s_wait_req changes only after clock edges or reset (registered count/state).

## Test plan
- Single write: s_wr addr 0x10 data 0xA5 with m_wait_req=0 → next cycle m_wr=1, m_addr=0x10, m_data=0xA5; following cycle count=0, m_wr=0.
- Backpressure/full: m_wait_req=1, push 5 writes (addr 0,4,8,C,10) → first 4 accepted, s_wait_req=1 on 5th, count=4; release m_wait_req → memory sees 0,4,8,C then 0x10 in order.
- Forwarding: m_wait_req=1, push (0x20,1) then (0x20,2); s_rd addr 0x20 → fwd_hit=1, fwd_data=2; addr 0x24 → fwd_hit=0, fwd_data=0.
- Simultaneous push/pop at count=2 with m_wait_req=0 → count stays 2; wrap-around after 10 writes keeps order.
- Flush: 3 pending, flush=1 → s_wait_req=1, s_wr ignored, flush_done pulses once count=0; flush on empty buffer → flush_done after one cycle.
- Reset mid-drain with count=3 → m_wr=0 and count=0 immediately; no further memory writes.
